// File: rtl/msk_zeros_sharing_arbiter.sv
// msk_zeros_sharing_arbiter: holds one PRNG word, turns it into a d-share
// sharing of an Nbits-wide zero, and hands each sharing to exactly one of
// NREQ requesters under round-robin arbitration. A word is delivered once.
module msk_zeros_sharing_arbiter #(
  parameter int d     = 2,
  parameter int Nbits = 128,
  parameter int NREQ  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [(d-1)*Nbits-1:0] rnd_in,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        gnt,
  output logic [d*Nbits-1:0]     zeros_out,
  output logic                   zeros_valid,
  output logic [15:0]            deliv_cnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (d-1)*Nbits;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e    buf_q, buf_d;
  logic [RW-1:0] rnd_buf_q, rnd_buf_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]   deliv_cnt_q, deliv_cnt_d;

  logic          hit, consume, load;
  logic [PW-1:0] win_idx;
  logic [Nbits-1:0] parity;

  // Round-robin scan: first asserted req starting at rr_ptr, wrapping mod NREQ
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int ix;
      ix = int'(rr_ptr_q) + k;
      if (ix >= NREQ) ix = ix - NREQ;
      if (!hit && req[ix]) begin
        hit     = 1'b1;
        win_idx = PW'(ix);
      end
    end
  end

  // Grant is the consumption of the buffered word; rst gates everything off
  always_comb begin
    consume   = ~rst & (buf_q == FULL) & hit;
    rnd_ready = ~rst & ((buf_q == EMPTY) | consume);
    load      = rnd_valid & rnd_ready;
    gnt       = '0;
    if (consume) gnt[win_idx] = 1'b1;
    zeros_valid = |gnt;
    deliv_cnt   = deliv_cnt_q;
  end

  // Next-state: buffer occupancy, captured word, pointer and delivery count
  always_comb begin
    buf_d       = buf_q;
    rnd_buf_d   = rnd_buf_q;
    rr_ptr_d    = rr_ptr_q;
    deliv_cnt_d = deliv_cnt_q;
    case (buf_q)
      EMPTY:   if (load) buf_d = FULL;
      FULL:    if (consume && !load) buf_d = EMPTY;
      default: buf_d = EMPTY;
    endcase
    if (load) rnd_buf_d = rnd_in;
    if (consume) begin
      rr_ptr_d    = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      deliv_cnt_d = deliv_cnt_q + 16'd1;
    end
  end

  // Sharing built only from the registered word; all-zero unless granted
  always_comb begin
    zeros_out = '0;
    parity    = '0;
    if (zeros_valid) begin
      for (int i = 0; i < d-1; i++) begin
        zeros_out[i*Nbits +: Nbits] = rnd_buf_q[i*Nbits +: Nbits];
        parity = parity ^ rnd_buf_q[i*Nbits +: Nbits];
      end
      zeros_out[(d-1)*Nbits +: Nbits] = parity;
    end
  end

  // State registers; reset discards any buffered word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q       <= EMPTY;
      rnd_buf_q   <= '0;
      rr_ptr_q    <= '0;
      deliv_cnt_q <= '0;
    end else begin
      buf_q       <= buf_d;
      rnd_buf_q   <= rnd_buf_d;
      rr_ptr_q    <= rr_ptr_d;
      deliv_cnt_q <= deliv_cnt_d;
    end
  end
endmodule

// File: tb/tb_msk_zeros_sharing_arbiter.sv
// Bench: directed scenarios plus random traffic against a queue-based model.
module tb_msk_zeros_sharing_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // d=2, Nbits=8, NREQ=4 instance
  logic        rst, rnd_valid, rnd_ready, zeros_valid;
  logic [7:0]  rnd_in;
  logic [3:0]  req, gnt;
  logic [15:0] zeros_out, deliv_cnt;

  // d=3 instance for the three-share layout
  logic        rst3, v3, rdy3, zv3;
  logic [15:0] rnd3, cnt3;
  logic [3:0]  req3, gnt3;
  logic [23:0] z3;

  msk_zeros_sharing_arbiter #(.d(2), .Nbits(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .req(req), .gnt(gnt), .zeros_out(zeros_out),
    .zeros_valid(zeros_valid), .deliv_cnt(deliv_cnt));

  msk_zeros_sharing_arbiter #(.d(3), .Nbits(8), .NREQ(4)) dut3 (
    .clk(clk), .rst(rst3), .rnd_in(rnd3), .rnd_valid(v3),
    .rnd_ready(rdy3), .req(req3), .gnt(gnt3), .zeros_out(z3),
    .zeros_valid(zv3), .deliv_cnt(cnt3));

  int nvec = 0;
  int nerr = 0;

  // Model: buffered words as a queue (depth <= 1), pointer and count as ints
  logic [7:0] mq[$];
  int         mptr;
  int         mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check before the next edge, then advance model
  task automatic step(input logic v, input logic [7:0] r, input logic [3:0] rq);
    bit          full;
    int          win;
    logic [3:0]  eg;
    logic [15:0] ez;
    bit          er;
    rnd_valid = v; rnd_in = r; req = rq;
    #2;
    full = (mq.size() != 0);
    win  = -1;
    if (full)
      for (int k = 0; k < 4; k++) begin
        int ix;
        ix = (mptr + k) % 4;
        if (win < 0 && rq[ix]) win = ix;
      end
    eg = 4'b0000;
    ez = 16'h0000;
    if (win >= 0) begin
      eg[win] = 1'b1;
      ez = {mq[0], mq[0]};
    end
    er = !full || (win >= 0);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("zeros_out", 32'(zeros_out), 32'(ez));
    chk("zeros_valid", 32'(zeros_valid), 32'(win >= 0));
    chk("rnd_ready", 32'(rnd_ready), 32'(er));
    chk("deliv_cnt", 32'(deliv_cnt), 32'(mcnt));
    @(posedge clk); #1;
    if (win >= 0) begin
      void'(mq.pop_front());
      mptr = (win + 1) % 4;
      mcnt = (mcnt + 1) % 65536;
    end
    if (v && er) mq.push_back(r);
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_zeros", 32'(zeros_out), 32'h0);
    chk("rst_zv", 32'(zeros_valid), 32'h0);
    chk("rst_ready", 32'(rnd_ready), 32'h0);
    chk("rst_cnt", 32'(deliv_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    mptr = 0;
    mcnt = 0;
  endtask

  initial begin
    rst = 1'b1; rnd_valid = 1'b1; rnd_in = 8'hA5; req = 4'b0000;
    rst3 = 1'b1; v3 = 1'b0; rnd3 = 16'h0; req3 = 4'b0000;
    mptr = 0; mcnt = 0;
    #3;
    chk("init_ready", 32'(rnd_ready), 32'h0);
    chk("init_gnt", 32'(gnt), 32'h0);
    chk("init_zeros", 32'(zeros_out), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load A5, then a new word is refused while full and nobody requests
    step(1'b1, 8'hA5, 4'b0000);
    step(1'b1, 8'h5A, 4'b0000);
    step(1'b1, 8'h77, 4'b0000);
    // Single requester takes the A5A5 sharing
    step(1'b0, 8'h00, 4'b0001);
    // Back-to-back streaming with every requester asserting
    step(1'b1, 8'h01, 4'b1111);
    for (int i = 2; i <= 6; i++) step(1'b1, 8'(i), 4'b1111);
    step(1'b0, 8'h00, 4'b1111);
    // Buffer drains, then grants stop while req stays high
    step(1'b1, 8'hC3, 4'b0000);
    step(1'b0, 8'h00, 4'b0100);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 4'b0100);
    step(1'b1, 8'h3C, 4'b0100);
    step(1'b0, 8'h00, 4'b0100);
    // Grant to requester 1, leave the buffer full, reset mid-cycle
    step(1'b1, 8'h99, 4'b0000);
    step(1'b1, 8'h44, 4'b0010);
    step(1'b0, 8'h00, 4'b0000);
    do_reset();
    step(1'b1, 8'h11, 4'b0000);
    step(1'b0, 8'h00, 4'b1111);
    step(1'b0, 8'h00, 4'b0000);

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom), ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom));
    end

    // Three-share layout: word 3C0F -> shares 0F, 3C, 33
    rst3 = 1'b0; v3 = 1'b1; rnd3 = 16'h3C0F; req3 = 4'b0000;
    #2;
    chk("d3_ready", 32'(rdy3), 32'h1);
    @(posedge clk); #1;
    v3 = 1'b0; rnd3 = 16'hFFFF; req3 = 4'b0010;
    #2;
    chk("d3_gnt", 32'(gnt3), 32'h2);
    chk("d3_zeros", 32'(z3), 32'h333C0F);
    chk("d3_zv", 32'(zv3), 32'h1);
    @(posedge clk); #1;
    #2;
    chk("d3_gnt_after", 32'(gnt3), 32'h0);
    chk("d3_zeros_after", 32'(z3), 32'h0);
    chk("d3_cnt", 32'(cnt3), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
